// File: rtl/n_bit_deserializer_if.sv
// n_bit_deserializer_if: strobe/serial input and parallel word/flag outputs of the deserializer
interface n_bit_deserializer_if #(parameter int n = 5);
  logic en;
  logic sin;
  logic [n-1:0] q;
  logic valid;
  logic perr;
  logic ferr;
  logic busy;
  modport master (output en, sin, input q, valid, perr, ferr, busy);
  modport slave (input en, sin, output q, valid, perr, ferr, busy);
endinterface

// File: rtl/n_bit_deserializer.sv
// n_bit_deserializer: LSB-first serial frame receiver with optional parity and framing check
module n_bit_deserializer #(
  parameter int n = 5,
  parameter int PARITY = 0
) (
  input logic clk,
  input logic rst,
  n_bit_deserializer_if.slave bus
);
  localparam int CW = $clog2(n);
  typedef enum logic [2:0] {IDLE, DATA, PAR, STOP, WAIT_HI} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [n-1:0] r_shift, r_q;
  logic r_par, r_valid, r_perr, r_ferr;
  logic w_last, w_take, w_ferr, w_perr;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (bus.en)
      case (r_state)
        IDLE: w_next = bus.sin ? IDLE : DATA;
        DATA: w_next = !w_last ? DATA : (PARITY != 0) ? PAR : STOP;
        PAR: w_next = STOP;
        STOP: w_next = bus.sin ? IDLE : WAIT_HI;
        default: w_next = bus.sin ? IDLE : WAIT_HI;
      endcase
  end
  always_comb begin
    w_last = r_cnt == CW'(n - 1);
    w_take = bus.en && r_state == STOP && bus.sin;
    w_ferr = bus.en && r_state == STOP && !bus.sin;
    w_perr = w_take && (PARITY != 0) && ((^r_shift ^ r_par) != (PARITY == 2));
  end
  // a mismatched parity still delivers the word; perr just rides along with valid
  always_ff @(posedge clk)
    if (rst) begin
      r_cnt <= '0;
      r_shift <= '0;
      r_q <= '0;
      r_par <= 1'b0;
      r_valid <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_valid <= w_take;
      r_perr <= w_perr;
      r_ferr <= w_ferr;
      if (bus.en && r_state == IDLE) r_cnt <= '0;
      if (bus.en && r_state == DATA) begin
        r_shift <= {bus.sin, r_shift[n-1:1]};
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      end
      if (bus.en && r_state == PAR) r_par <= bus.sin;
      if (w_take) r_q <= r_shift;
    end
  assign bus.q = r_q;
  assign bus.valid = r_valid;
  assign bus.perr = r_perr;
  assign bus.ferr = r_ferr;
  assign bus.busy = r_state != IDLE;
endmodule

// File: tb/tb_n_bit_deserializer.sv
// tb_n_bit_deserializer: table-driven check of the even-parity receiver plus a back-to-back no-parity sequence
module tb_n_bit_deserializer;
  logic clk = 1'b0;
  logic rst;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  n_bit_deserializer_if #(.n(5)) ia ();
  n_bit_deserializer_if #(.n(5)) ib ();
  n_bit_deserializer #(.n(5), .PARITY(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  n_bit_deserializer #(.n(5), .PARITY(0)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  typedef struct packed {
    logic r, e, s;
    logic [4:0] q;
    logic v, p, f, b;
  } vec_t;
  vec_t tv[$];
  function automatic void add(logic r, logic e, logic s, logic [4:0] q, logic v, logic p, logic f, logic b);
    vec_t x;
    x = '{r, e, s, q, v, p, f, b};
    tv.push_back(x);
  endfunction
  task automatic frame(logic [4:0] d, logic par, logic stp, logic [4:0] qprev, logic [4:0] qnew, logic perr);
    add(0, 1, 0, qprev, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 1, d[i], qprev, 0, 0, 0, 1);
    add(0, 1, par, qprev, 0, 0, 0, 1);
    if (stp) add(0, 1, 1, qnew, 1, perr, 0, 0);
    else add(0, 1, 0, qprev, 0, 0, 1, 1);
  endtask
  logic [0:13] bs;
  logic [4:0] gq;
  logic [8:0] got, exp_v;
  int first_pulse, second_pulse;
  initial begin
    rst = 1'b1;
    ia.en = 1'b0; ia.sin = 1'b1;
    ib.en = 1'b0; ib.sin = 1'b1;
    add(1, 0, 1, 5'b00000, 0, 0, 0, 0);
    add(0, 1, 1, 5'b00000, 0, 0, 0, 0);
    frame(5'b10110, 1, 1, 5'b00000, 5'b10110, 0);
    add(0, 1, 1, 5'b10110, 0, 0, 0, 0);
    frame(5'b10110, 0, 1, 5'b10110, 5'b10110, 1);
    add(0, 1, 1, 5'b10110, 0, 0, 0, 0);
    frame(5'b00011, 0, 0, 5'b10110, 5'b10110, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 5'b10110, 0, 0, 0, 1);
    add(0, 1, 1, 5'b10110, 0, 0, 0, 0);
    // strobe gaps: every en=0 edge drives the opposite level and must be ignored
    add(0, 1, 0, 5'b10110, 0, 0, 0, 1);
    add(0, 0, 1, 5'b10110, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      add(0, 1, i == 0 || i == 3, 5'b10110, 0, 0, 0, 1);
      add(0, 0, !(i == 0 || i == 3), 5'b10110, 0, 0, 0, 1);
    end
    add(0, 1, 0, 5'b10110, 0, 0, 0, 1);
    add(0, 0, 1, 5'b10110, 0, 0, 0, 1);
    add(0, 1, 1, 5'b01001, 1, 0, 0, 0);
    add(0, 0, 0, 5'b01001, 0, 0, 0, 0);
    add(0, 1, 1, 5'b01001, 0, 0, 0, 0);
    add(0, 1, 0, 5'b01001, 0, 0, 0, 1);
    add(0, 1, 1, 5'b01001, 0, 0, 0, 1);
    add(0, 1, 0, 5'b01001, 0, 0, 0, 1);
    add(0, 1, 1, 5'b01001, 0, 0, 0, 1);
    add(1, 1, 0, 5'b00000, 0, 0, 0, 0);
    frame(5'b00001, 1, 1, 5'b00000, 5'b00001, 0);
    add(0, 1, 1, 5'b00001, 0, 0, 0, 0);
    foreach (tv[k]) begin
      rst = tv[k].r; ia.en = tv[k].e; ia.sin = tv[k].s;
      @(posedge clk); #1;
      got = {ia.q, ia.valid, ia.perr, ia.ferr, ia.busy};
      exp_v = {tv[k].q, tv[k].v, tv[k].p, tv[k].f, tv[k].b};
      n_vec++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL vec%0d q/valid/perr/ferr/busy got %b want %b", k, got, exp_v);
      end
    end
    rst = 1'b1; ia.en = 1'b0; ia.sin = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bs = 14'b01111110000001;
    first_pulse = -1; second_pulse = -1;
    for (int i = 0; i < 14; i++) begin
      ib.en = 1'b1; ib.sin = bs[i];
      @(posedge clk); #1;
      n_vec++;
      if (ib.valid !== (i == 6 || i == 13) || ib.ferr !== 1'b0 || ib.perr !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b step%0d valid/perr/ferr got %b%b%b want %b00", i, ib.valid, ib.perr, ib.ferr, i == 6 || i == 13);
      end
      if (ib.valid === 1'b1) begin
        if (first_pulse < 0) first_pulse = i; else second_pulse = i;
        gq = (i == 6) ? 5'b11111 : 5'b00000;
        n_vec++;
        if (ib.q !== gq) begin
          n_bad++;
          $display("FAIL b2b q step%0d got %b want %b", i, ib.q, gq);
        end
      end
    end
    n_vec++;
    if (second_pulse - first_pulse != 7) begin
      n_bad++;
      $display("FAIL b2b spacing got %0d want 7", second_pulse - first_pulse);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
